// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i pipeline's memory stage and the data-memory responder.
package rv32i_pkg;

  // Responder transaction phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Memory-type opcodes and word-access funct3 codes used by the MEM stage.
  localparam logic [6:0] M_TYPE_LOAD  = 7'b0000011;
  localparam logic [6:0] M_TYPE_STORE = 7'b0100011;
  localparam logic [2:0] F3_LW        = 3'b010;
  localparam logic [2:0] F3_SW        = 3'b010;

  // Default array geometry and access latency.
  localparam int DMEM_DEPTH   = 32;
  localparam int DMEM_ADDR_W  = 5;
  localparam int DMEM_LATENCY = 2;

  // Byte-lane merge: lanes with a set strobe take the new word, others keep the old one.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 data storage with byte-masked synchronous write, registered read
// port and a synchronous clear of every word while RN is low.
module dmem_array
  import rv32i_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic [31:0]       rdata
);

  logic [31:0] mem_r [DEPTH];

  // Word storage: full clear during reset, otherwise a byte-masked store.
  always_ff @(posedge clk) begin
    if (!RN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (wr_en) begin
      mem_r[addr] <= merge_bytes(mem_r[addr], wdata, wstrb);
    end
  end

  // Read register: captures a word on a load, zero for stores/errors, else holds.
  always_ff @(posedge clk) begin
    if (!RN) begin
      rdata <= 32'h0000_0000;
    end else if (rd_en) begin
      rdata <= mem_r[addr];
    end else if (rd_clr) begin
      rdata <= 32'h0000_0000;
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder: accepts one word request at a time, performs the
// access LATENCY cycles after acceptance and returns a held response.
module rv32i_dmem_responder
  import rv32i_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic        clk,
  input  logic        RN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // Counter preload: WAIT lasts LATENCY edges including the access edge.
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  dmem_state_e       state_r;
  dmem_state_e       state_s;
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic              err_r;
  logic              ready_r;
  logic              valid_r;
  logic              rsp_err_r;
  logic              accept_s;
  logic              access_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              rd_clr_s;
  logic [31:0]       rdata_s;

  // Next-state and strobe decode for the request/wait/response sequence.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    access_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && ready_r) begin
          accept_s = 1'b1;
          state_s  = WAIT;
        end else begin
          state_s  = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          access_s = 1'b1;
          state_s  = RESP;
        end else begin
          state_s  = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; ready/valid are registered copies of the next phase so
  // req_ready stays low throughout reset and rises on the first released edge.
  always_ff @(posedge clk) begin
    if (!RN) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
      valid_r <= (state_s == RESP);
    end
  end

  // Latency counter: preloaded on accept, counts down while waiting.
  always_ff @(posedge clk) begin
    if (!RN) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= LAT_M1;
    end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Request capture: inputs are sampled only on the accept edge; the range
  // check uses the full 32-bit address so aliasing indices still flag errors.
  always_ff @(posedge clk) begin
    if (!RN) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      wstrb_r <= 4'h0;
      err_r   <= 1'b0;
    end else if (accept_s) begin
      we_r    <= req_we;
      addr_r  <= req_addr[ADDR_W-1:0];
      wdata_r <= req_wdata;
      wstrb_r <= req_wstrb;
      err_r   <= (req_addr >= DEPTH_W);
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wstrb_r <= wstrb_r;
      err_r   <= err_r;
    end
  end

  // Response error flag: set on the access edge and held through RESP.
  always_ff @(posedge clk) begin
    if (!RN) begin
      rsp_err_r <= 1'b0;
    end else if (access_s) begin
      rsp_err_r <= err_r;
    end else begin
      rsp_err_r <= rsp_err_r;
    end
  end

  // Access strobes into the array on the WAIT exit edge.
  always_comb begin
    wr_en_s  = access_s && we_r && !err_r;
    rd_en_s  = access_s && !we_r && !err_r;
    rd_clr_s = access_s && (we_r || err_r);
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem_array (
    .clk    (clk),
    .RN     (RN),
    .wr_en  (wr_en_s),
    .rd_en  (rd_en_s),
    .rd_clr (rd_clr_s),
    .addr   (addr_r),
    .wdata  (wdata_r),
    .wstrb  (wstrb_r),
    .rdata  (rdata_s)
  );

  assign req_ready = ready_r;
  assign rsp_valid = valid_r;
  assign rsp_rdata = rdata_s;
  assign rsp_err   = rsp_err_r;

endmodule

// File: doc/rv32i_dmem_responder.md
Name: rv32i_dmem_responder

Overview:
- Data-memory responder: the slave end of the load/store path driven by the rv32i pipeline's MEM stage.
- Accepts one word-addressed read or write request at a time over a valid/ready handshake.
- Performs the access after a fixed, parameterised latency, then returns a response over a second valid/ready handshake.
- Replaces the pipeline-internal DM array, so the pipeline can be exercised against realistic, non-zero-latency memory.

Parameters:
- DEPTH, 32, number of 32-bit words in the array.
- ADDR_W, 5, index width; must equal clog2(DEPTH).
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- RN  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  32  word address, same indexing as the pipeline's EX_MEM ALU output.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte enables for stores; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  address out of range (req_addr >= DEPTH).

Behaviour:
- Reset: RN sampled low at a clk edge forces the following.
  - State IDLE, counter 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All DEPTH words cleared to 0.
  - req_ready is 1 from the first edge with RN high.
  - While RN is low, req_ready=0 and no request is accepted.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready:
    - latch we/addr/wdata/wstrb;
    - compute err = (req_addr >= DEPTH) over the full 32 bits;
    - load counter = LATENCY-1;
    - go to WAIT.
  - WAIT: req_ready=0.
    - If counter != 0, decrement it.
    - If counter == 0, perform the access and go to RESP.
  - RESP: req_ready=0, rsp_valid=1.
    - rsp_rdata and rsp_err are held stable until rsp_ready=1.
    - On rsp_valid&&rsp_ready, go to IDLE and drop rsp_valid.
- Access rules, executed on the WAIT exit edge:
  - Store, no error: mem[addr[ADDR_W-1:0]] byte lane i <= wdata lane i wherever wstrb[i]=1. rsp_rdata=0.
  - Load, no error: rsp_rdata <= mem[addr[ADDR_W-1:0]]; this is a full word, and no sign or width handling is done here.
  - Error: no memory write, rsp_rdata=0, rsp_err=1.
  - Store with wstrb=0: legal; no bytes change and the response is still generated.
- Timing: request accepted at edge N, access at edge N+LATENCY, rsp_valid high immediately after edge N+LATENCY.
  - Minimum turnaround is LATENCY+2 cycles per transaction when rsp_ready is tied high.
- Ordering: one outstanding transaction, so responses are strictly in request order.
  - A load after a store to the same address always returns the stored data.
- Backpressure: rsp_ready low holds RESP indefinitely.
  - No new request is accepted until the response handshake completes, so a requester's req_valid may stay high while waiting.
- Inputs sampled only on the accept edge: later changes to req_* have no effect on the in-flight transaction.
- Reset mid-operation: RN low in WAIT or RESP aborts the transaction and applies the full reset above.
  - A store not yet committed is discarded.
  - No response is issued.

Decomposition:
- Shared package rv32i_pkg:
  - state enum {IDLE, WAIT, RESP};
  - M_TYPE opcode and LW/SW funct3 constants (shared with the pipeline's MEM stage);
  - default DEPTH and LATENCY constants.
- Sub-module dmem_array: DEPTH x 32 storage.
  - Synchronous byte-masked write, synchronous read.
  - Synchronous clear on RN low.
  - The top block holds the FSM, counter and handshake logic.

Test Plan:
- Reset then idle: RN low 2 cycles then high -> req_ready=1, rsp_valid=0, rsp_rdata=0; a load from every address 0..31 returns 0 with rsp_err=0.
- Store/load, LATENCY=2, rsp_ready=1: SW addr 3, data 0xDEADBEEF, wstrb 0xF -> rsp_valid exactly 2 cycles after accept, rdata 0; LW addr 3 -> rdata 0xDEADBEEF.
- Byte strobes: preload addr 5 = 0x11223344, SW 0xAABBCCDD with wstrb 0x5 -> LW addr 5 returns 0x11BB33DD.
- Backpressure: LW with rsp_ready low for 6 cycles, req_valid held high with a new request -> rsp_valid and rdata stable, req_ready=0 throughout; second request accepted only after the handshake.
- Out of range: SW addr 32, data 0x1234 -> rsp_err=1, rdata 0; a load from addr 0 is unchanged; LW addr 0xFFFFFFFF -> rsp_err=1.
- Reset in WAIT: SW addr 7, data 0x55 with LATENCY=4; RN low on the cycle after accept -> no response; after reset, LW addr 7 returns 0.
